// File: rtl/aes_round_sequencer.sv
// Round-level sequencer for the AES round datapath. It requests round keys by index,
// stalls on key_valid, strobes each round, and aborts when the key generator stops responding.
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       aes_enable,
  input  logic       opt_mode,
  input  logic       key_valid,
  output logic       state_load,
  output logic       round_en,
  output logic       final_round,
  output logic       inv,
  output logic [3:0] key_idx,
  output logic [3:0] round_ct,
  output logic       busy,
  output logic       enc_done,
  output logic       key_timeout
);

  typedef enum logic [2:0] {IDLE, PRE, ROUND, FINAL, DONE, ABORT} state_t;

  localparam logic [3:0] NR_IDX    = 4'(NR);
  localparam logic [7:0] STALL_MAX = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [3:0] round_nxt;
  logic       inv_nxt;
  logic [7:0] stall_ct, stall_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      round_ct <= '0;
      inv      <= 1'b0;
      stall_ct <= '0;
    end else begin
      state    <= state_nxt;
      round_ct <= round_nxt;
      inv      <= inv_nxt;
      stall_ct <= stall_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    round_nxt   = round_ct;
    inv_nxt     = inv;
    stall_nxt   = stall_ct;
    state_load  = 1'b0;
    round_en    = 1'b0;
    final_round = 1'b0;
    key_idx     = '0;

    // Stall accounting shared by every key-consuming state; a strobe below overrides it.
    if (state == PRE || state == ROUND || state == FINAL) begin
      if (!key_valid) begin
        if (stall_ct == STALL_MAX) state_nxt = ABORT;
        else                       stall_nxt = stall_ct + 8'd1;
      end else begin
        stall_nxt = '0;
      end
    end

    case (state)
      IDLE: begin
        if (aes_enable) begin
          inv_nxt   = opt_mode;
          round_nxt = '0;
          stall_nxt = '0;
          state_nxt = PRE;
        end
      end
      PRE: begin
        key_idx = inv ? NR_IDX : 4'd0;
        if (key_valid) begin
          state_load = 1'b1;
          round_nxt  = 4'd1;
          state_nxt  = ROUND;
        end
      end
      ROUND: begin
        key_idx = inv ? (NR_IDX - round_ct) : round_ct;
        if (key_valid) begin
          round_en  = 1'b1;
          round_nxt = round_ct + 4'd1;
          if (round_ct == NR_IDX - 4'd1) state_nxt = FINAL;
        end
      end
      FINAL: begin
        key_idx = inv ? 4'd0 : NR_IDX;
        if (key_valid) begin
          round_en    = 1'b1;
          final_round = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE, ABORT: begin
        round_nxt = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign enc_done    = (state == DONE);
  assign key_timeout = (state == ABORT);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized and directed bench for aes_round_sequencer: two instances (NR=10/TIMEOUT=16 and
// NR=14/TIMEOUT=6) compared every cycle against a round-step reference model.
module tb_aes_round_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic aes_enable = 1'b0;
  logic opt_mode = 1'b0;
  logic key_valid = 1'b0;

  logic       sl0, re0, fr0, iv0, bz0, ed0, kt0;
  logic [3:0] ki0, rc0;
  logic       sl1, re1, fr1, iv1, bz1, ed1, kt1;
  logic [3:0] ki1, rc1;

  int errors = 0;
  int checks = 0;
  logic ed0_s, ed1_s, kt0_s, kt1_s, bz0_s;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(10), .TIMEOUT(16)) u0 (
    .clk(clk), .rst(rst), .aes_enable(aes_enable), .opt_mode(opt_mode), .key_valid(key_valid),
    .state_load(sl0), .round_en(re0), .final_round(fr0), .inv(iv0), .key_idx(ki0),
    .round_ct(rc0), .busy(bz0), .enc_done(ed0), .key_timeout(kt0)
  );

  aes_round_sequencer #(.NR(14), .TIMEOUT(6)) u1 (
    .clk(clk), .rst(rst), .aes_enable(aes_enable), .opt_mode(opt_mode), .key_valid(key_valid),
    .state_load(sl1), .round_en(re1), .final_round(fr1), .inv(iv1), .key_idx(ki1),
    .round_ct(rc1), .busy(bz1), .enc_done(ed1), .key_timeout(kt1)
  );

  // Reference: phase 0 idle, 1 working on key step s (0 = add-key, NR = final), 2 done, 3 abort.
  typedef struct packed {
    logic [1:0] ph;
    logic [4:0] s;
    logic       inv;
    logic [8:0] stall;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mstep(int nr, int to, mdl_t m, logic en, logic om, logic kv);
    mdl_t n = m;
    case (m.ph)
      2'd0: if (en) begin n.ph = 2'd1; n.s = '0; n.inv = om; n.stall = '0; end
      2'd1: begin
        if (kv) begin
          n.stall = '0;
          if (int'(m.s) == nr) n.ph = 2'd2;
          else                 n.s = m.s + 5'd1;
        end else if (int'(m.stall) == to - 1) begin
          n.ph = 2'd3;
        end else begin
          n.stall = m.stall + 9'd1;
        end
      end
      default: n.ph = 2'd0;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mstep(10, 16, m0, aes_enable, opt_mode, key_valid);
      m1 <= mstep(14, 6, m1, aes_enable, opt_mode, key_valid);
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp(input string p, input int nr, input mdl_t m, input logic kv,
                     input logic sl, input logic re, input logic fr, input logic iv,
                     input logic [3:0] ki, input logic [3:0] rc,
                     input logic bz, input logic ed, input logic kt);
    bit act = (m.ph == 2'd1);
    int s = int'(m.s);
    check({p, "state_load"},  int'(sl), int'(act && kv && s == 0));
    check({p, "round_en"},    int'(re), int'(act && kv && s != 0));
    check({p, "final_round"}, int'(fr), int'(act && kv && s == nr));
    check({p, "inv"},         int'(iv), int'(m.inv));
    check({p, "busy"},        int'(bz), int'(m.ph != 2'd0));
    check({p, "enc_done"},    int'(ed), int'(m.ph == 2'd2));
    check({p, "key_timeout"}, int'(kt), int'(m.ph == 2'd3));
    if (m.ph < 2'd2) begin
      check({p, "key_idx"},  int'(ki), act ? (m.inv ? nr - s : s) : 0);
      check({p, "round_ct"}, int'(rc), act ? s : 0);
    end
  endtask

  task automatic tick(input logic en, input logic om, input logic kv, input logic r);
    @(negedge clk);
    aes_enable = en;
    opt_mode   = om;
    key_valid  = kv;
    rst        = r;
    #1;
    cmp("u0.", 10, m0, kv, sl0, re0, fr0, iv0, ki0, rc0, bz0, ed0, kt0);
    cmp("u1.", 14, m1, kv, sl1, re1, fr1, iv1, ki1, rc1, bz1, ed1, kt1);
    ed0_s = ed0; ed1_s = ed1; kt0_s = kt0; kt1_s = kt1; bz0_s = bz0;
  endtask

  function automatic logic kv_pat(int mode, int k);
    case (mode)
      1:       return !(k inside {[1:3], 9, 10});
      2:       return k <= 5;
      default: return 1'b1;
    endcase
  endfunction

  // Cycle k of the block is the k-th cycle after the edge that samples aes_enable.
  task automatic run_block(input logic om, input int mode, input int n,
                           output int dn0, output int dn1, output int to0);
    dn0 = -1; dn1 = -1; to0 = -1;
    tick(1'b1, om, 1'b1, 1'b0);
    for (int k = 1; k <= n; k++) begin
      tick(1'b0, 1'($urandom % 2), kv_pat(mode, k), 1'b0);
      if (ed0_s && dn0 < 0) dn0 = k;
      if (ed1_s && dn1 < 0) dn1 = k;
      if (kt0_s && to0 < 0) to0 = k;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int dn0, dn1, to0, cnt0, cnt1, burst;

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    run_block(1'b0, 0, 20, dn0, dn1, to0);
    check("enc_done_cycle_nr10", dn0, 12);
    check("enc_done_cycle_nr14", dn1, 16);
    idle(2);

    run_block(1'b1, 0, 20, dn0, dn1, to0);
    check("dec_done_cycle_nr10", dn0, 12);
    check("dec_done_cycle_nr14", dn1, 16);
    idle(2);

    run_block(1'b0, 1, 25, dn0, dn1, to0);
    check("stall_done_cycle_nr10", dn0, 17);
    check("stall_done_cycle_nr14", dn1, 21);
    idle(2);

    run_block(1'b0, 2, 25, dn0, dn1, to0);
    check("timeout_cycle", to0, 22);
    check("timeout_no_done", dn0, -1);
    idle(2);

    tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_busy_immediate", int'(bz0_s), 0);
    cnt0 = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0);
      cnt0 += int'(ed0_s) + int'(kt0_s);
    end
    check("rst_no_done_or_timeout", cnt0, 0);

    cnt0 = 0; cnt1 = 0;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      tick(1'b1, 1'($urandom % 2), 1'b1, 1'b0);
      cnt0 += int'(ed0_s);
      cnt1 += int'(ed1_s);
    end
    check("held_enable_blocks_nr10", cnt0, 2);
    check("held_enable_blocks_nr14", cnt1, 1);

    burst = 0;
    for (int k = 0; k < 3000; k++) begin
      logic kv;
      if (burst > 0) begin
        kv = 1'b0;
        burst--;
      end else if ($urandom % 16 == 0) begin
        kv = 1'b0;
        burst = $urandom_range(1, 20);
      end else begin
        kv = ($urandom % 5) != 0;
      end
      tick(1'($urandom % 4 == 0), 1'($urandom % 2), kv, 1'($urandom % 500 == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
# aes_round_sequencer

Round-level sequencer between the AES controller and the AES round datapath. On a start pulse from the controller (`aes_enable`) it runs the initial AddRoundKey step and NR cipher rounds. It requests round keys by index from the key generator and stalls while a requested key is not yet valid. It issues one strobe per round to the datapath and returns a one-cycle `enc_done` pulse to the controller. It supports encrypt and decrypt ordering and aborts with a timeout if the key generator stops responding.

## Interface
Parameters:
- NR, 10, number of cipher rounds; legal values 10, 12, 14.
- TIMEOUT, 16, consecutive cycles of `key_valid` low that trigger an abort; legal values 2..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- aes_enable  in  1  start request from the controller; sampled only in IDLE.
- opt_mode  in  1  0 = encrypt, 1 = decrypt; latched when `aes_enable` is accepted.
- key_valid  in  1  the round key at `key_idx` is available this cycle.
- state_load  out  1  datapath loads the input block and XORs it with round key `key_idx`.
- round_en  out  1  datapath performs one round using round key `key_idx`.
- final_round  out  1  qualifies `round_en`; datapath skips (Inv)MixColumns.
- inv  out  1  latched `opt_mode`; datapath uses inverse transforms.
- key_idx  out  4  requested round-key index.
- round_ct  out  4  current round number (0 = pre-addkey).
- busy  out  1  high in every state except IDLE.
- enc_done  out  1  one-cycle pulse when the block is complete.
- key_timeout  out  1  one-cycle pulse when a round is aborted by timeout.

## Operation
- States: IDLE, PRE, ROUND, FINAL, DONE, ABORT.
- IDLE:
  - all outputs 0 except `inv`, which holds its last latched value (0 after reset);
  - `aes_enable`=1 latches `opt_mode` into `inv`, sets `round_ct`=0 and moves to PRE.
- PRE: `key_idx` = 0 for encrypt, NR for decrypt.
  - If `key_valid`=1: `state_load`=1 for that cycle, `round_ct` becomes 1, next state is ROUND (or FINAL when NR=1, which is illegal and not supported).
  - If `key_valid`=0: hold state and outputs, no strobe.
- ROUND: serves rounds 1..NR-1; `key_idx` = `round_ct` (encrypt) or NR-`round_ct` (decrypt).
  - If `key_valid`=1: `round_en`=1 and `round_ct` increments.
  - When the round just served is NR-1, the next state is FINAL.
- FINAL: `key_idx` = NR (encrypt) or 0 (decrypt).
  - If `key_valid`=1: `round_en`=1 and `final_round`=1, then go to DONE.
- DONE: `enc_done`=1 for exactly one cycle, then return to IDLE.
- Stall counter:
  - clears on every strobe and on entry to PRE;
  - increments each cycle in PRE/ROUND/FINAL while `key_valid`=0.
- Timeout: when the stall counter reaches TIMEOUT-1 with `key_valid` still 0, go to ABORT.
  - ABORT asserts `key_timeout`=1 for one cycle, then returns to IDLE.
  - No `enc_done` is issued for an aborted block.
- `aes_enable` outside IDLE is ignored, including in DONE and ABORT.
- `opt_mode` changes while busy have no effect.
- `state_load` and `round_en` are never high in the same cycle.
- Exactly one strobe is issued per `key_valid`-qualified cycle in PRE/ROUND/FINAL.
- `busy` is driven from the state register; `enc_done` is the decode of DONE.
- Outputs depend only on state, `round_ct`, `inv` and `key_valid`; there are no other combinational paths.

## Timing
- Reset: state IDLE; `round_ct`=0, `key_idx`=0, `inv`=0, stall counter 0, all strobes and pulses 0. Takes effect immediately (asynchronous).
- `rst` mid-block: the block is discarded and no `enc_done` or `key_timeout` is issued. After `rst` falls, the first rising edge with `aes_enable`=1 starts a new block.
- Latency with `key_valid` held high, counting from the edge that samples `aes_enable` as edge 0:
  - cycle 1: PRE;
  - cycles 2..NR: ROUND;
  - cycle NR+1: FINAL;
  - cycle NR+2: DONE.
  - For NR=10, `enc_done` is high in cycle 12, and the next start can be sampled at the end of cycle 13 (IDLE).
- Each stall cycle adds exactly one cycle of latency.
- `key_idx` is stable for the whole cycle in which `key_valid` is sampled.
- `key_idx` changes only after an accepted strobe or a state change.
- Abort fires TIMEOUT cycles after the last strobe (or after PRE entry); `key_timeout` is high in the following cycle.

## Test plan
- Encrypt, NR=10, `key_valid`=1: `aes_enable` pulse -> `state_load` in cycle 1 with `key_idx` 0; `round_en` in cycles 2..11 with `key_idx` 1..10; `final_round` only in cycle 11; `enc_done` only in cycle 12; `busy` high in cycles 1..12.
- Decrypt, NR=10: `opt_mode`=1 at start -> `inv`=1; `key_idx` sequence 10,9,...,0 across `state_load` and the 10 rounds; `enc_done` in cycle 12.
- Stalls: `key_valid` low for 3 cycles in PRE and 2 cycles at round 5 -> same strobe and `key_idx` sequence, `enc_done` in cycle 17; `key_idx` held constant during each stall.
- Timeout, TIMEOUT=16: `key_valid` dropped permanently after round 4 -> `key_timeout` pulses 17 cycles after the round-4 strobe; no `enc_done`; back in IDLE with `busy`=0 on the next cycle.
- Reset and ignored starts: `rst` asserted in cycle 6 -> all outputs 0 immediately and no `enc_done`. `aes_enable` held high through a full block -> ignored while busy; the next block starts only from IDLE.
- NR=14 encrypt: `enc_done` in cycle 16, `final_round` with `key_idx`=14.
